// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the instruction decoder.
// Chooses the next PC from jump/branch strobes and keeps retire/redirect counters.
module pc_fetch_unit #(
    parameter int PC_W = 12,
    parameter int RC_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             BR,
    input  logic             JP,
    input  logic             my_bne,
    input  logic             my_blt,
    input  logic             my_jal,
    input  logic             my_jr,
    input  logic             my_bex,
    input  logic             isNotEqual,
    input  logic             lt_true,
    input  logic             rstatus_nz,
    input  logic [16:0]      imm,
    input  logic [26:0]      target,
    input  logic [31:0]      rd_data,
    output logic [PC_W-1:0]  address_imem,
    output logic [PC_W-1:0]  pc,
    output logic [31:0]      pc_plus1,
    output logic             inst_valid,
    output logic             redirect,
    output logic [31:0]      retired_count,
    output logic [RC_W-1:0]  redirect_count
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_retired;
    logic [RC_W-1:0]   r_redirects;

    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_br_target;
    logic [PC_W-1:0]   w_next_pc;
    logic              w_take;
    logic              w_br_taken;
    logic              w_unused;

    // my_jal only steers the writeback mux downstream; upper operand bits are beyond the PC range.
    assign w_unused = ^{my_jal, imm[16:PC_W], target[26:PC_W], rd_data[31:PC_W]};

    assign w_pc_inc    = r_pc + PC_W'(1);
    assign w_br_target = w_pc_inc + imm[PC_W-1:0];
    assign w_br_taken  = BR & ((my_bne & isNotEqual) | (my_blt & lt_true));

    always_comb begin
        w_next_pc = w_pc_inc;
        w_take    = 1'b0;
        if (my_jr) begin
            w_next_pc = rd_data[PC_W-1:0];
            w_take    = 1'b1;
        end else if (JP) begin
            w_next_pc = target[PC_W-1:0];
            w_take    = 1'b1;
        end else if (my_bex & rstatus_nz) begin
            w_next_pc = target[PC_W-1:0];
            w_take    = 1'b1;
        end else if (w_br_taken) begin
            w_next_pc = w_br_target;
            w_take    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        address_imem = '0;
        inst_valid   = 1'b0;
        redirect     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                inst_valid   = 1'b1;
                redirect     = w_take & ~stall;
                address_imem = stall ? r_pc : w_next_pc;
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    // pc tracks the address presented to the synchronous imem one edge earlier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= address_imem;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired   <= '0;
            r_redirects <= '0;
        end else begin
            if ((r_state == S_RUN) && !stall) begin
                r_retired <= r_retired + 32'd1;
            end
            if (redirect && (r_redirects != {RC_W{1'b1}})) begin
                r_redirects <= r_redirects + RC_W'(1);
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus1       = {{(32-PC_W){1'b0}}, w_pc_inc};
    assign retired_count  = r_retired;
    assign redirect_count = r_redirects;

endmodule
